systolic_seq_ctrl: RTL

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_seq_ctrl_pkg.sv | 26 ++
 rtl/systolic_seq_ctrl_if.sv | 52 +++++
 rtl/systolic_seq_ctrl_phase_cnt.sv | 33 +++
 rtl/systolic_seq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state encoding,
// default array geometry and the pipeline latency formula.
// Optional feature macro used by the slice: SEQ_CTRL_PERF_EN (busy-cycle counter).
package systolic_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_CW = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD_W  = 2'd1,
      S_COMPUTE = 2'd2,
      S_DONE    = 2'd3
   } seq_state_t;

   // Cycles from the first activation read to the first result row.
   function automatic int lat_of(input int n);
      return 2 * n - 1;
   endfunction

   // Weight-row index width; a 1x1 array still gets a 1-bit index.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Control/status bundle between the sequencer (slave) and its user (master).
// With SEQ_CTRL_PERF_EN defined the bundle also carries perf_cycles.
//
// Handshake: start is a one-cycle request sampled only while the sequencer is
// idle; a start seen while busy is dropped, never queued. num_rows is sampled
// together with an accepted start. hold freezes sequencing for as long as it is
// high (only while loading weights or computing). All outputs are registered;
// each strobe and its address change in the same cycle.
interface systolic_seq_ctrl_if
   import systolic_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int CW = DEF_CW
);
   localparam int AW = addr_w(N);

   logic          start;
   logic [CW-1:0] num_rows;
   logic          hold;
   logic          switch;
   logic          w_rd;
   logic [AW-1:0] w_addr;
   logic          a_rd;
   logic [CW-1:0] a_addr;
   logic [N-1:0]  skew_en;
   logic          o_valid;
   logic [CW-1:0] o_addr;
   logic          busy;
   logic          done;
`ifdef SEQ_CTRL_PERF_EN
   logic [15:0]   perf_cycles;
`endif

   modport master (
      output start, num_rows, hold,
      input  switch, w_rd, w_addr, a_rd, a_addr, skew_en,
      input  o_valid, o_addr, busy, done
`ifdef SEQ_CTRL_PERF_EN
      , input perf_cycles
`endif
   );

   modport slave (
      input  start, num_rows, hold,
      output switch, w_rd, w_addr, a_rd, a_addr, skew_en,
      output o_valid, o_addr, busy, done
`ifdef SEQ_CTRL_PERF_EN
      , output perf_cycles
`endif
   );

endinterface

// File: rtl/systolic_seq_ctrl_phase_cnt.sv
// Phase counter with synchronous clear (priority) and enable; the next value
// is exposed so the owner can register outputs in step with the count.
module seq_phase_cnt #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_nxt
);

   // Next count: clear wins, otherwise advance when enabled.
   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else if (en) begin
         cnt_nxt = cnt + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: loads N weight rows,
// then streams M activation rows with a diagonal per-row skew and captures M
// result rows LAT cycles later. Outputs are registered from next-state values.
// Optional: SEQ_CTRL_PERF_EN adds a saturating 16-bit busy-cycle counter.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int CW  = DEF_CW,
   parameter int LAT = lat_of(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   systolic_seq_ctrl_if.slave  bus,
   output seq_state_t          state_dbg
);

   // Counters are two bits wider than the row count so LAT+M-1 never wraps.
   localparam int KW = CW + 2;
   localparam int AW = addr_w(N);
   localparam logic [KW-1:0] LAT_K  = KW'(LAT);
   localparam logic [KW-1:0] N_LAST = KW'(N - 1);

   seq_state_t    state, state_nxt;
   logic [CW-1:0] m;
   logic [KW-1:0] mx, last_k;
   logic [KW-1:0] wc, wc_nxt, k, k_nxt;
   logic          freeze;
   logic          w_clr, w_en, k_clr, k_en;

   logic          switch_nxt, w_rd_nxt, a_rd_nxt, o_valid_nxt, busy_nxt, done_nxt;
   logic [AW-1:0] w_addr_nxt;
   logic [CW-1:0] a_addr_nxt, o_addr_nxt;
   logic [N-1:0]  skew_nxt;

   assign mx        = {2'b00, m};
   assign last_k    = LAT_K + mx - KW'(1);
   assign freeze    = bus.hold && (state == S_LOAD_W || state == S_COMPUTE);
   assign state_dbg = state;

   // Each counter runs only in its own state and clears on any state change.
   assign w_clr = (state_nxt != S_LOAD_W);
   assign w_en  = (state == S_LOAD_W) && !bus.hold;
   assign k_clr = (state_nxt != S_COMPUTE);
   assign k_en  = (state == S_COMPUTE) && !bus.hold;

   seq_phase_cnt #(.W(KW)) u_w_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_clr),
      .en      (w_en),
      .cnt     (wc),
      .cnt_nxt (wc_nxt)
   );

   seq_phase_cnt #(.W(KW)) u_k_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (k_clr),
      .en      (k_en),
      .cnt     (k),
      .cnt_nxt (k_nxt)
   );

   // Next-state decision; hold freezes only the two active phases.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_LOAD_W;
         end
         S_LOAD_W: begin
            if (!bus.hold && wc == N_LAST) state_nxt = (m == '0) ? S_DONE : S_COMPUTE;
         end
         S_COMPUTE: begin
            if (!bus.hold && k == last_k) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Row count is latched only when a start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m <= '0;
      end else if (state == S_IDLE && bus.start) begin
         m <= bus.num_rows;
      end
   end

   // Output decode from next state/counts; addresses move only with their strobe.
   always_comb begin
      switch_nxt  = 1'b0;
      w_rd_nxt    = 1'b0;
      w_addr_nxt  = bus.w_addr;
      a_rd_nxt    = 1'b0;
      a_addr_nxt  = bus.a_addr;
      skew_nxt    = '0;
      o_valid_nxt = 1'b0;
      o_addr_nxt  = bus.o_addr;
      busy_nxt    = (state_nxt != S_IDLE);
      done_nxt    = (state_nxt == S_DONE);
      case (state_nxt)
         S_LOAD_W: begin
            switch_nxt = 1'b1;
            if (!freeze) begin
               w_rd_nxt   = 1'b1;
               w_addr_nxt = AW'(wc_nxt);
            end
         end
         S_COMPUTE: begin
            if (!freeze) begin
               a_rd_nxt = (k_nxt < mx);
               if (a_rd_nxt) a_addr_nxt = CW'(k_nxt);
               for (int i = 0; i < N; i++) begin
                  skew_nxt[i] = (k_nxt >= KW'(i)) && (k_nxt < KW'(i) + mx);
               end
               o_valid_nxt = (k_nxt >= LAT_K) && (k_nxt < LAT_K + mx);
               if (o_valid_nxt) o_addr_nxt = CW'(k_nxt - LAT_K);
            end
         end
         default: begin
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.switch  <= 1'b0;
         bus.w_rd    <= 1'b0;
         bus.w_addr  <= '0;
         bus.a_rd    <= 1'b0;
         bus.a_addr  <= '0;
         bus.skew_en <= '0;
         bus.o_valid <= 1'b0;
         bus.o_addr  <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         bus.switch  <= switch_nxt;
         bus.w_rd    <= w_rd_nxt;
         bus.w_addr  <= w_addr_nxt;
         bus.a_rd    <= a_rd_nxt;
         bus.a_addr  <= a_addr_nxt;
         bus.skew_en <= skew_nxt;
         bus.o_valid <= o_valid_nxt;
         bus.o_addr  <= o_addr_nxt;
         bus.busy    <= busy_nxt;
         bus.done    <= done_nxt;
      end
   end

`ifdef SEQ_CTRL_PERF_EN
   logic [15:0] perf;

   // Busy-cycle counter: cleared on accepted start, saturates, frozen when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf <= '0;
      end else if (state == S_IDLE && bus.start) begin
         perf <= '0;
      end else if (state != S_IDLE && perf != 16'hFFFF) begin
         perf <= perf + 16'd1;
      end
   end

   assign bus.perf_cycles = perf;
`endif

endmodule
